rca_adder_4bit_reg: RTL and testbench

- 4-bit unsigned ripple-carry adder with a registered output stage.
- Computes A + B through an explicit chain of four 1-bit full-adder stages and registers the 4-bit sum and carry-out on the clock.
- Used as a small arithmetic leaf block; its waveform is dumped for inspection in simulation.

---
 rtl/rca_adder_4bit_reg.sv | 67 ++++++
 tb/tb_rca_adder_4bit_reg.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rca_adder_4bit_reg.sv
// 4-bit unsigned ripple-carry adder with a registered sum/carry output.
// The ripple chain is built from four explicit full-adder stages; the only
// state is the output register, so results appear one clock after A/B.

// Single-bit full adder used as one stage of the ripple chain.
module rca_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    logic p;

    // Propagate term is shared between the sum and the carry expressions.
    assign p    = a_i ^ b_i;
    assign s_o  = p ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & p);
endmodule

module rca_adder_4bit_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] sum,
    output logic       cout
);
    localparam int NUM_STAGES = 4;

    // carry[i] is the carry into stage i; carry[NUM_STAGES] is the raw carry-out.
    logic [NUM_STAGES:0]   carry;
    logic [NUM_STAGES-1:0] sum_d;
    logic                  cout_d;
    logic [NUM_STAGES-1:0] sum_q;
    logic                  cout_q;

    assign carry[0] = 1'b0;

    // One full adder per bit, carry rippling from bit 0 upward.
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        rca_fa u_fa (
            .a_i  (A[i]),
            .b_i  (B[i]),
            .ci_i (carry[i]),
            .s_o  (sum_d[i]),
            .co_o (carry[i+1])
        );
    end

    assign cout_d = carry[NUM_STAGES];

    // Output register: reset clears immediately, otherwise capture the
    // combinational result every edge (no enable, no handshake).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_rca_adder_4bit_reg.sv
// Scoreboard bench for rca_adder_4bit_reg: the driver changes operands on
// the falling edge and queues the expected {cout,sum}; the monitor pops and
// compares just after each rising edge.
module tb_rca_adder_4bit_reg;
    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] sum;
    logic       cout;

    typedef struct {
        logic [4:0] exp;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rca_adder_4bit_reg dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Direct comparison used for checks between clock edges.
    task automatic check_now(input string name, input logic [4:0] exp);
        checks++;
        if ({cout, sum} !== exp) begin
            errors++;
            $display("FAIL %s: got %b_%h, expected %b_%h", name, cout, sum, exp[4], exp[3:0]);
        end
    endtask

    // Drive new operands on the falling edge and queue the result the
    // following rising edge must produce.
    task automatic apply(input logic [3:0] a, input logic [3:0] b,
                         input logic [4:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        A = a;
        B = b;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic push_exp(input logic [4:0] exp, input string name);
        exp_t e;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: sample away from the edge and compare against the queue head.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if ({cout, sum} !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %b_%h, expected %b_%h",
                             e.name, cout, sum, e.exp[4], e.exp[3:0]);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        A   = 4'd5;
        B   = 4'd5;
        #1;
        check_now("reset_before_clk", 5'd0);

        // Clock runs with operands 5+5 but reset held: outputs stay zero.
        repeat (3) apply(4'd5, 4'd5, 5'd0, "reset_held");

        // Release reset together with the first operand pair.
        @(negedge clk);
        rst = 1'b0;
        A = 4'd0;
        B = 4'd0;
        push_exp(5'd0, "add_0_0");
        apply(4'd1, 4'd0, 5'd1, "add_1_0");
        apply(4'd1, 4'd1, 5'd2, "add_1_1");
        apply(4'd3, 4'd2, 5'd5, "add_3_2");

        // Boundaries: wrap-around and maximum.
        apply(4'd15, 4'd1,  5'b1_0000, "wrap_15_1");
        apply(4'd15, 4'd15, 5'b1_1110, "max_15_15");
        apply(4'd8,  4'd8,  5'b1_0000, "carry_8_8");
        apply(4'd10, 4'd5,  5'b0_1111, "no_carry_10_5");

        // Exhaustive sweep, one pair per cycle.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [3:0] av;
                logic [3:0] bv;
                av = a[3:0];
                bv = b[3:0];
                apply(av, bv, {1'b0, av} + {1'b0, bv}, "sweep");
            end
        end

        // Asynchronous reset pulse between edges.
        apply(4'd7, 4'd9, 5'b1_0000, "pre_pulse_7_9");
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_now("async_reset_clears", 5'd0);
        #1 rst = 1'b0;
        #1;
        check_now("zero_until_edge", 5'd0);
        push_exp(5'b1_0000, "post_pulse_7_9");

        // Mid-cycle operand change is invisible until the next edge.
        apply(4'd2, 4'd1, 5'd3, "add_2_1");
        @(negedge clk);
        A = 4'd6;
        #2;
        check_now("hold_before_edge", 5'd3);
        push_exp(5'd7, "add_6_1");

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: got %0d pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
